// File: rtl/eth_pkg.sv
// Shared definitions for the uplink mux: FSM encoding, abort-beat constants
// and a constant-evaluable clog2 used for parameter-derived widths.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    // Abort beat marks exactly one valid byte and flags the frame as errored
    localparam logic ABORT_KEEP_LSB = 1'b1;
    localparam logic ABORT_USER     = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational packet arbiter: optional strict priority for ch0, otherwise
// first requester at or after the round-robin pointer, wrapping at NUM_CH.
module eth_rr_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PRIO_CH0 = 1,
    parameter int PTR_W    = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (PRIO_CH0 != 0 && req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_uplink_mux.sv
// Packet-atomic N:1 AXI-Stream mux for the uplink TX MAC with a registered
// output stage and a stall watchdog that terminates starved packets.
module eth_uplink_mux
    import eth_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 64,
    parameter int PRIO_CH0 = 1,
    parameter int TIMEOUT  = 1024,
    localparam int KEEP_W  = DATA_W / 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    input  logic [NUM_CH-1:0]        s_axis_tuser,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic [NUM_CH-1:0]        o_grant,
    output logic                     o_abort
);

    localparam int PTR_W  = clog2(NUM_CH);
    localparam int WD_W   = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t              state, state_nxt;
    logic [NUM_CH-1:0]   grant, arb_grant;
    logic [PTR_W-1:0]    gidx, arb_idx, ptr;
    logic [WD_W-1:0]     wd;

    logic                sel_valid, sel_last, sel_user;
    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic                out_free, accept, take_beat, load_abort, pkt_done, fire;

    eth_rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .PRIO_CH0 (PRIO_CH0),
        .PTR_W    (PTR_W)
    ) u_arb (
        .req   (s_axis_tvalid),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (arb_grant[i]) arb_idx = PTR_W'(i);
    end

    always_comb begin
        sel_valid = s_axis_tvalid[gidx];
        sel_last  = s_axis_tlast[gidx];
        sel_user  = s_axis_tuser[gidx];
        sel_data  = s_axis_tdata[int'(gidx)*DATA_W +: DATA_W];
        sel_keep  = s_axis_tkeep[int'(gidx)*KEEP_W +: KEEP_W];
    end

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign o_grant  = grant;
    assign o_abort  = fire;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // A late beat in the firing cycle is accepted, so fire requires !sel_valid
    always_comb begin
        state_nxt     = state;
        s_axis_tready = '0;
        accept        = 1'b0;
        take_beat     = 1'b0;
        load_abort    = 1'b0;
        pkt_done      = 1'b0;
        fire          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|s_axis_tvalid) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                s_axis_tready = grant & {NUM_CH{out_free}};
                accept        = out_free && sel_valid;
                take_beat     = accept;
                if (accept && sel_last) begin
                    state_nxt = ST_IDLE;
                    pkt_done  = 1'b1;
                end else if (TIMEOUT != 0 && !sel_valid && wd == WD_W'(WD_LIM)) begin
                    fire      = 1'b1;
                    state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (out_free) begin
                    load_abort = 1'b1;
                    state_nxt  = ST_DROP;
                end
            end
            ST_DROP: begin
                s_axis_tready = grant;
                accept        = sel_valid;
                if (accept && sel_last) begin
                    state_nxt = ST_IDLE;
                    pkt_done  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Priority grants of ch0 leave the pointer alone so the RR pool keeps its turn
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
            wd    <= '0;
        end else begin
            if (state == ST_IDLE && |s_axis_tvalid) begin
                grant <= arb_grant;
                gidx  <= arb_idx;
                wd    <= '0;
            end
            if (pkt_done) begin
                grant <= '0;
                if (PRIO_CH0 == 0 || gidx != '0)
                    ptr <= (gidx == PTR_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
            end
            if (state == ST_XFER) begin
                if (accept)          wd <= '0;
                else if (!sel_valid) wd <= wd + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (take_beat) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tlast  <= sel_last;
            m_axis_tuser  <= sel_user;
        end else if (load_abort) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= {{(KEEP_W-1){1'b0}}, ABORT_KEEP_LSB};
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= ABORT_USER;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_uplink_mux.sv
// Bench for eth_uplink_mux: cycle table for a single packet, then queue-based
// sources with a packet-level scoreboard for priority, RR, random, abort, reset.
module tb_eth_uplink_mux;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int KW = 8;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
        logic [4:0]  gap;
    } beat_t;

    typedef struct packed {
        logic        v;
        logic        l;
        logic        rdy;
        logic [63:0] d;
        logic [7:0]  k;
        logic [2:0]  eg;
        logic [2:0]  esr;
        logic        emv;
        logic [63:0] emd;
        logic [7:0]  emk;
        logic        eml;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    s_valid, s_last, s_user;
    logic [N*DW-1:0] s_data;
    logic [N*KW-1:0] s_keep;
    logic            m_rdy;

    logic [N-1:0] sr_a, g_a, sr_b, g_b, sr, g;
    logic         mv_a, ml_a, mu_a, ab_a, mv_b, ml_b, mu_b, ab_b, mv, ml, mu, ab;
    logic [DW-1:0] md_a, md_b, md;
    logic [KW-1:0] mk_a, mk_b, mk;
    logic          use_b;

    eth_uplink_mux #(.NUM_CH(N), .DATA_W(DW), .PRIO_CH0(1), .TIMEOUT(16)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user), .s_axis_tready(sr_a),
        .m_axis_tvalid(mv_a), .m_axis_tdata(md_a), .m_axis_tkeep(mk_a),
        .m_axis_tlast(ml_a), .m_axis_tuser(mu_a), .m_axis_tready(m_rdy),
        .o_grant(g_a), .o_abort(ab_a));

    eth_uplink_mux #(.NUM_CH(N), .DATA_W(DW), .PRIO_CH0(0), .TIMEOUT(16)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
        .s_axis_tlast(s_last), .s_axis_tuser(s_user), .s_axis_tready(sr_b),
        .m_axis_tvalid(mv_b), .m_axis_tdata(md_b), .m_axis_tkeep(mk_b),
        .m_axis_tlast(ml_b), .m_axis_tuser(mu_b), .m_axis_tready(m_rdy),
        .o_grant(g_b), .o_abort(ab_b));

    always_comb begin
        sr = use_b ? sr_b : sr_a;
        g  = use_b ? g_b  : g_a;
        mv = use_b ? mv_b : mv_a;
        md = use_b ? md_b : md_a;
        mk = use_b ? mk_b : mk_a;
        ml = use_b ? ml_b : ml_a;
        mu = use_b ? mu_b : mu_a;
        ab = use_b ? ab_b : ab_a;
    end

    beat_t    src_q[N][$];
    beat_t    exp_q[N][$];
    int       gap_left[N];
    bit       loaded[N];
    int       acc_cnt[N];
    logic [N-1:0] acc, prev_g;
    int       grant_log[$], pkt_log[$];
    int       cur_ch, stall_cnt, abort_cnt, abort_at, rdy_pct;
    int       n_vec, n_err;
    vec_t     tbl[9];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_log(input int q[$]);
        logic [31:0] r;
        r = '0;
        foreach (q[i]) r = (r << 4) | 32'(q[i] + 1);
        return r;
    endfunction

    task automatic score();
        beat_t e;
        int    tag;
        if (cur_ch < 0) begin
            tag = int'(md[63:56]);
            if (tag < N && exp_q[tag].size() > 0) begin
                cur_ch = tag;
                pkt_log.push_back(tag);
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL pkt_start: got beat %h with no packet pending for it", md);
                return;
            end
        end
        if (exp_q[cur_ch].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_beat: got %h on ch%0d, expected none", md, cur_ch);
            return;
        end
        e = exp_q[cur_ch].pop_front();
        chk("beat", {md, mk, ml, mu}, {e.d, e.k, e.l, e.u});
        if (ml) cur_ch = -1;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                void'(src_q[k].pop_front());
                loaded[k] = 1'b0;
            end
            if (!loaded[k] && src_q[k].size() > 0) begin
                loaded[k]   = 1'b1;
                gap_left[k] = int'(src_q[k][0].gap);
            end
            if (loaded[k] && gap_left[k] == 0) begin
                s_valid[k]           = 1'b1;
                s_data[k*DW +: DW]   = src_q[k][0].d;
                s_keep[k*KW +: KW]   = src_q[k][0].k;
                s_last[k]            = src_q[k][0].l;
                s_user[k]            = src_q[k][0].u;
            end else begin
                s_valid[k] = 1'b0;
                if (loaded[k]) gap_left[k]--;
            end
        end
        m_rdy = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic tick();
        int gi;
        @(negedge clk);
        acc = s_valid & sr;
        for (int k = 0; k < N; k++) acc_cnt[k] += int'(acc[k]);
        if (mv && m_rdy) score();
        if (g != '0 && prev_g == '0) begin
            gi = 0;
            for (int k = 0; k < N; k++) if (g[k]) gi = k;
            grant_log.push_back(gi);
            stall_cnt = 0;
        end
        prev_g = g;
        if (|acc)                                 stall_cnt = 0;
        else if (g != '0 && (g & s_valid) == '0) stall_cnt++;
        if (ab) begin
            abort_cnt++;
            abort_at = stall_cnt;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
            loaded[k]  = 1'b0;
            acc_cnt[k] = 0;
        end
        s_valid = '0;
        acc     = '0;
        cur_ch  = -1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_rdy = 1'b1;
        clear_model();
        grant_log.delete();
        pkt_log.delete();
        prev_g    = '0;
        stall_cnt = 0;
        abort_cnt = 0;
        abort_at  = -1;
        @(negedge clk);
        chk("reset_a", {sr_a, mv_a, md_a, mk_a, ml_a, mu_a, g_a, ab_a}, '0);
        chk("reset_b", {sr_b, mv_b, md_b, mk_b, ml_b, mu_b, g_b, ab_b}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_pkt(input int ch, input int len, input int pid, input int maxgap);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d   = {8'(ch), 8'hA5, 16'(pid), 8'(i), 24'($urandom)};
            b.l   = (i == len - 1);
            b.k   = b.l ? (8'hFF >> $urandom_range(7)) : 8'hFF;
            b.u   = 1'($urandom_range(1));
            b.gap = 5'($urandom_range(maxgap));
            src_q[ch].push_back(b);
            exp_q[ch].push_back(b);
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int pend;
        for (int i = 0; i < budget; i++) begin
            pend = 0;
            for (int k = 0; k < N; k++) pend += src_q[k].size() + exp_q[k].size();
            if (pend == 0 && !mv && g == '0) break;
            tick();
        end
        pend = 0;
        for (int k = 0; k < N; k++) pend += src_q[k].size() + exp_q[k].size();
        chk(nm, {32'(pend), mv, g}, '0);
    endtask

    localparam logic [63:0] D0 = 64'h0100_0000_CAFE_0000;
    localparam logic [63:0] D1 = 64'h0100_0001_BEEF_1111;
    localparam logic [63:0] D2 = 64'h0100_0002_F00D_2222;
    localparam logic [63:0] D3 = 64'h0100_0003_D00D_3333;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [72:0] gp, ep;
        beat_t       b;
        rst = 1'b1; use_b = 1'b0; m_rdy = 1'b1; rdy_pct = 100;
        s_valid = '0; s_last = '0; s_user = '0; s_data = '0; s_keep = '0;
        n_vec = 0; n_err = 0;

        // single ch1 packet, then output hold under backpressure
        tbl[0] = '{1'b1, 1'b0, 1'b1, D0, 8'hFF, 3'b000, 3'b000, 1'b0, 64'h0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, D0, 8'hFF, 3'b010, 3'b010, 1'b0, 64'h0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, D1, 8'hFF, 3'b010, 3'b010, 1'b1, D0,    8'hFF, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, D2, 8'hFF, 3'b010, 3'b010, 1'b1, D1,    8'hFF, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, D3, 8'h0F, 3'b010, 3'b010, 1'b1, D2,    8'hFF, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, D3, 8'h0F, 3'b000, 3'b000, 1'b1, D3,    8'h0F, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, D3, 8'h0F, 3'b000, 3'b000, 1'b1, D3,    8'h0F, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, D3, 8'h0F, 3'b000, 3'b000, 1'b1, D3,    8'h0F, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, D3, 8'h0F, 3'b000, 3'b000, 1'b0, 64'h0, 8'h00, 1'b0};

        do_reset();
        for (int r = 0; r < 9; r++) begin
            s_valid = {1'b0, tbl[r].v, 1'b0};
            s_last  = {1'b0, tbl[r].l, 1'b0};
            s_user  = '0;
            s_data  = {~tbl[r].d, tbl[r].d, ~tbl[r].d};
            s_keep  = {~tbl[r].k, tbl[r].k, ~tbl[r].k};
            m_rdy   = tbl[r].rdy;
            @(negedge clk);
            gp = mv_a ? {ml_a, mk_a, md_a} : '0;
            ep = tbl[r].emv ? {tbl[r].eml, tbl[r].emk, tbl[r].emd} : '0;
            chk($sformatf("table_row%0d", r), {g_a, sr_a, mv_a, mu_a, gp},
                {tbl[r].eg, tbl[r].esr, tbl[r].emv, 1'b0, ep});
            @(posedge clk);
            #1;
        end
        s_valid = '0;

        // strict priority, no pre-emption of an in-flight ch2 packet
        do_reset();
        rdy_pct = 100;
        add_pkt(0, 3, 1, 0);
        add_pkt(2, 4, 1, 0);
        for (int i = 0; i < 100 && g_a != 3'b100; i++) tick();
        add_pkt(0, 2, 2, 0);
        wait_idle("prio_drain", 200);
        chk("prio_grant_order", enc_log(grant_log), 32'h131);
        chk("prio_pkt_order", enc_log(pkt_log), 32'h131);

        // plain round robin on the PRIO_CH0=0 instance
        use_b = 1'b1;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < N; c++) add_pkt(c, 2, p, 0);
        wait_idle("rr_drain", 300);
        chk("rr_grant_order", enc_log(grant_log), 32'h123123);
        use_b = 1'b0;

        // random backpressure and source gaps, 20 packets per channel
        do_reset();
        rdy_pct = 50;
        for (int c = 0; c < N; c++)
            for (int p = 0; p < 20; p++) add_pkt(c, $urandom_range(1, 6), p, 2);
        wait_idle("random_drain", 8000);

        // ch1 starves after two beats: abort beat then drop the remainder
        do_reset();
        rdy_pct = 100;
        for (int i = 0; i < 5; i++) begin
            b.d   = {8'd1, 8'h5A, 16'd7, 8'(i), 24'($urandom)};
            b.k   = (i == 4) ? 8'h3F : 8'hFF;
            b.l   = (i == 4);
            b.u   = 1'b0;
            b.gap = (i == 2) ? 5'd20 : 5'd0;
            src_q[1].push_back(b);
            if (i < 2) exp_q[1].push_back(b);
        end
        b = '{d: 64'h0, k: 8'h01, l: 1'b1, u: 1'b1, gap: 5'd0};
        exp_q[1].push_back(b);
        add_pkt(1, 3, 8, 0);
        wait_idle("abort_drain", 300);
        chk("abort_pulses", 128'(abort_cnt), 128'd1);
        chk("abort_stall_cycle", 128'(abort_at), 128'd16);

        // reset while ch2 is three beats into a six-beat packet
        do_reset();
        rdy_pct = 100;
        add_pkt(2, 6, 3, 0);
        for (int i = 0; i < 200 && acc_cnt[2] < 3; i++) tick();
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        chk("midpkt_reset", {sr_a, mv_a, md_a, mk_a, ml_a, mu_a, g_a, ab_a}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_g = '0;
        rdy_pct = 50;
        add_pkt(2, 4, 4, 1);
        wait_idle("after_reset_drain", 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
